// File: rtl/scene_sequencer.sv
// scene_sequencer: game-flow controller for the 96x64 RGB565 OLED path.
// Runs the MENU/PLAY/PAUSE/OVER screen FSM and commits requested screen
// changes only at frame_begin. It also selects the scene pixel stream,
// blinks a border while paused, and returns from OVER to MENU after a
// frame timeout.
// Optional build macro SCENE_SEQUENCER_FADE_EN adds a 3-frame fade-in
// after every state commit. The border overlay is never faded.
//
// Request protocol: btn_start, btn_pause and game_over are single-cycle
// pulses. A legal pulse is latched into a pending target on the cycle it
// arrives. The pending target commits to state on the next frame_begin. A
// pulse coinciding with frame_begin is judged against the state being
// committed on that edge, so it commits one frame later.
module scene_sequencer #(
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned OVER_FRAMES   = 180,
  parameter logic [15:0] BORDER_COLOUR = 16'hFFE0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        game_over,
  input  logic [15:0] menu_data,
  input  logic [15:0] play_data,
  input  logic [15:0] over_data,
  output logic [15:0] oled_data,
  output logic        play_active,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_MENU  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [9:0] OVER_LAST  = 10'(OVER_FRAMES - 1);

  state_e      state_q, state_d;
  state_e      pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  state_e      commit_tgt, base, req_tgt;
  logic        req_v;
  logic        over_done;
  logic        entering;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [9:0]  over_cnt_q, over_cnt_d;
  logic [15:0] pix_q, pix_d;
  logic [15:0] scene_pix;
  logic [15:0] faded_pix;
  logic        on_border;

  // Next state, pending-request capture and legality check.
  always_comb begin
    over_done  = (state_q == ST_OVER) && (over_cnt_q == OVER_LAST);
    commit_tgt = state_q;
    if (pend_v_q) begin
      commit_tgt = pend_q;
    end else if (over_done) begin
      commit_tgt = ST_MENU;
    end
    state_d = frame_begin ? commit_tgt : state_q;

    // Requests are judged against where the screen is heading, not where it is.
    base = frame_begin ? commit_tgt : (pend_v_q ? pend_q : state_q);

    req_v   = 1'b0;
    req_tgt = base;
    if (game_over && (base == ST_PLAY)) begin
      req_v   = 1'b1;
      req_tgt = ST_OVER;
    end else if (btn_pause && (base == ST_PLAY)) begin
      req_v   = 1'b1;
      req_tgt = ST_PAUSE;
    end else if (btn_pause && (base == ST_PAUSE)) begin
      req_v   = 1'b1;
      req_tgt = ST_PLAY;
    end else if (btn_start && (base == ST_MENU)) begin
      req_v   = 1'b1;
      req_tgt = ST_PLAY;
    end else if (btn_start && ((base == ST_PAUSE) || (base == ST_OVER))) begin
      req_v   = 1'b1;
      req_tgt = ST_MENU;
    end

    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    if (frame_begin) begin
      pend_v_d = 1'b0;
    end
    if (req_v) begin
      // A request that leads back to the upcoming state cancels the pending change.
      if (req_tgt == state_d) begin
        pend_v_d = 1'b0;
      end else begin
        pend_v_d = 1'b1;
        pend_d   = req_tgt;
      end
    end

    entering = frame_begin && (state_d != state_q);
  end

  // Blink and over frame counters; both advance only on frame_begin.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    over_cnt_d  = over_cnt_q;
    if (entering && (state_d == ST_PAUSE)) begin
      blink_cnt_d = 8'd0;
      phase_d     = 1'b1;
    end else if (frame_begin && (state_q == ST_PAUSE)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
    if (entering && (state_d == ST_OVER)) begin
      over_cnt_d = 10'd0;
    end else if (frame_begin && (state_q == ST_OVER) && !over_done) begin
      over_cnt_d = over_cnt_q + 10'd1;
    end
  end

`ifdef SCENE_SEQUENCER_FADE_EN
  logic [1:0] fade_q, fade_d;

  // Fade level: jumps to 3 on each commit, then steps down once per frame.
  always_comb begin
    fade_d = fade_q;
    if (entering) begin
      fade_d = 2'd3;
    end else if (frame_begin && (fade_q != 2'd0)) begin
      fade_d = fade_q - 2'd1;
    end
  end

  // Fade register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_q <= 2'd0;
    end else begin
      fade_q <= fade_d;
    end
  end

  // Shift each colour field by the fade level independently.
  always_comb begin
    faded_pix = {scene_pix[15:11] >> fade_q,
                 scene_pix[10:5]  >> fade_q,
                 scene_pix[4:0]   >> fade_q};
  end
`else
  // Without fading the selected scene pixel goes straight to the overlay stage.
  always_comb begin
    faded_pix = scene_pix;
  end
`endif

  // Scene pixel mux plus pause border overlay, which applies only to visible columns.
  always_comb begin
    case (state_q)
      ST_MENU:  scene_pix = menu_data;
      ST_OVER:  scene_pix = over_data;
      default:  scene_pix = play_data;
    endcase
    on_border = (x <= 7'd95) &&
                ((x == 7'd0) || (x == 7'd95) || (y == 6'd0) || (y == 6'd63));
    pix_d = faded_pix;
    if ((state_q == ST_PAUSE) && phase_q && on_border) begin
      pix_d = BORDER_COLOUR;
    end
  end

  // All state registers; reset may arrive at any point in a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_MENU;
      pend_q      <= ST_MENU;
      pend_v_q    <= 1'b0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
      over_cnt_q  <= 10'd0;
      pix_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      over_cnt_q  <= over_cnt_d;
      pix_q       <= pix_d;
    end
  end

  assign oled_data   = pix_q;
  assign state       = state_q;
  assign play_active = (state_q == ST_PLAY);

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer built with BLINK_FRAMES=2 and OVER_FRAMES=3.
// Stimulus tasks push the expected {state, oled_data} for each probed pixel.
// A negedge monitor pops and compares one cycle later.
module tb_scene_sequencer;

  localparam logic [15:0] MENU_C   = 16'h07E0;
  localparam logic [15:0] PLAY_C   = 16'h001F;
  localparam logic [15:0] OVER_C   = 16'hF81F;
  localparam logic [15:0] BORDER_C = 16'hFFE0;

  logic        clk;
  logic        rst_n;
  logic        frame_begin;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        btn_start;
  logic        btn_pause;
  logic        game_over;
  logic [15:0] menu_data;
  logic [15:0] play_data;
  logic [15:0] over_data;
  logic [15:0] oled_data;
  logic        play_active;
  logic [1:0]  state;

  logic [17:0] exp_q[$];
  logic [17:0] exp_e;
  logic        pix_v;
  logic        pix_v_d;
  int          n_vec;
  int          n_bad;

  scene_sequencer #(
    .BLINK_FRAMES (2),
    .OVER_FRAMES  (3),
    .BORDER_COLOUR(16'hFFE0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_begin(frame_begin),
    .x          (x),
    .y          (y),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .game_over  (game_over),
    .menu_data  (menu_data),
    .play_data  (play_data),
    .over_data  (over_data),
    .oled_data  (oled_data),
    .play_active(play_active),
    .state      (state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Probe flag delayed to the cycle the registered pixel appears
  always_ff @(posedge clk) pix_v_d <= pix_v;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (pix_v_d) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard: got output expected none queued");
      end else begin
        exp_e = exp_q.pop_front();
        chk("oled_data", {16'd0, oled_data}, {16'd0, exp_e[15:0]});
        chk("state", {30'd0, state}, {30'd0, exp_e[17:16]});
        chk("play_active", {31'd0, play_active}, {31'd0, exp_e[17:16] == 2'd1});
      end
    end
  end

  // Driver tasks
  task automatic cyc(input logic fb, input logic bs, input logic bp, input logic go);
    frame_begin = fb;
    btn_start   = bs;
    btn_pause   = bp;
    game_over   = go;
    @(posedge clk);
    #1;
    frame_begin = 1'b0;
    btn_start   = 1'b0;
    btn_pause   = 1'b0;
    game_over   = 1'b0;
    pix_v       = 1'b0;
  endtask

  task automatic fb();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic px(input logic [6:0] cx, input logic [5:0] cy,
                    input logic [15:0] ep, input logic [1:0] es);
    x     = cx;
    y     = cy;
    pix_v = 1'b1;
    exp_q.push_back({es, ep});
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    pix_v       = 1'b0;
    frame_begin = 1'b0;
    btn_start   = 1'b0;
    btn_pause   = 1'b0;
    game_over   = 1'b0;
    x           = 7'd0;
    y           = 6'd0;
    menu_data   = MENU_C;
    play_data   = PLAY_C;
    over_data   = OVER_C;
    rst_n       = 1'b1;

    // Reset block
    #1 rst_n = 1'b0;
    #2;
    chk("reset_oled", {16'd0, oled_data}, 32'd0);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_active", {31'd0, play_active}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // MENU shows menu_data
    fb();
    px(7'd10, 6'd10, MENU_C, 2'd0);
    px(7'd95, 6'd63, MENU_C, 2'd0);

    // btn_start mid-frame commits only at frame_begin
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    px(7'd20, 6'd5, MENU_C, 2'd0);
    fb();
    px(7'd0, 6'd0, PLAY_C, 2'd1);
    play_data = 16'h1234;
    px(7'd50, 6'd20, 16'h1234, 2'd1);
    play_data = PLAY_C;

    // PAUSE blink with BLINK_FRAMES=2: border on frames 1-2, 5-6
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int f = 1; f <= 6; f++) begin
      fb();
      px(7'd0,  6'd0,  ((f <= 2) || (f >= 5)) ? BORDER_C : PLAY_C, 2'd2);
      px(7'd95, 6'd63, ((f <= 2) || (f >= 5)) ? BORDER_C : PLAY_C, 2'd2);
      px(7'd40, 6'd30, PLAY_C, 2'd2);
      if (f == 1) px(7'd100, 6'd0, PLAY_C, 2'd2);
    end

    // PAUSE -> PLAY
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    fb();
    px(7'd0, 6'd0, PLAY_C, 2'd1);

    // Double pause in one frame is a no-op
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    fb();
    px(7'd0, 6'd0, PLAY_C, 2'd1);

    // game_over beats btn_pause; OVER auto-returns at the third frame_begin
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    px(7'd5, 6'd5, PLAY_C, 2'd1);
    fb();
    px(7'd5, 6'd5, OVER_C, 2'd3);
    fb();
    px(7'd5, 6'd5, OVER_C, 2'd3);
    fb();
    px(7'd5, 6'd5, OVER_C, 2'd3);
    fb();
    px(7'd5, 6'd5, MENU_C, 2'd0);

    // Illegal requests in MENU are ignored
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    fb();
    px(7'd5, 6'd5, MENU_C, 2'd0);

    // OVER left by btn_start in the second frame, single transition
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    fb();
    px(7'd5, 6'd5, PLAY_C, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    fb();
    px(7'd5, 6'd5, OVER_C, 2'd3);
    fb();
    px(7'd5, 6'd5, OVER_C, 2'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    px(7'd5, 6'd5, OVER_C, 2'd3);
    fb();
    px(7'd5, 6'd5, MENU_C, 2'd0);
    fb();
    px(7'd5, 6'd5, MENU_C, 2'd0);
    fb();
    px(7'd5, 6'd5, MENU_C, 2'd0);

    // Request coinciding with frame_begin commits one frame later
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    px(7'd7, 6'd7, MENU_C, 2'd0);
    fb();
    px(7'd7, 6'd7, PLAY_C, 2'd1);

    // PAUSE -> MENU on btn_start
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    fb();
    px(7'd0, 6'd0, BORDER_C, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    fb();
    px(7'd0, 6'd0, MENU_C, 2'd0);

    // Asynchronous reset mid-frame in PAUSE, with a pending request outstanding
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    fb();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    fb();
    px(7'd0, 6'd0, BORDER_C, 2'd2);
    px(7'd40, 6'd30, PLAY_C, 2'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oled", {16'd0, oled_data}, 32'd0);
    chk("async_rst_state", {30'd0, state}, 32'd0);
    chk("async_rst_active", {31'd0, play_active}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fb();
    px(7'd10, 6'd10, MENU_C, 2'd0);
    fb();
    px(7'd0, 6'd0, MENU_C, 2'd0);

    // Drain the scoreboard, bounded
    for (int i = 0; (i < 20) && (exp_q.size() > 0); i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
